mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Data-memory access controller for the MEM stage of the 5-stage MIPS pipeline.
- Sits between the EX_MEM pipeline register (upstream) and an external variable-latency data memory. Its load result feeds the MEM_WB register (downstream).
- Stores are posted into a small in-order store buffer. Loads block the pipeline via stall_o until data returns.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.
- SB_DEPTH, 4, store buffer entries; power of 2, minimum 2.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_read_i  in  1  MemRead from EX_MEM.
- req_write_i  in  1  MemWrite from EX_MEM.
- addr_i  in  ADDR_W  ALU result from EX_MEM.
- wdata_i  in  DATA_W  store data from EX_MEM.
- rdata_o  out  DATA_W  load result to MEM_WB.
- stall_o  out  1  freezes PC, IF_ID, ID_EX and EX_MEM, and inserts a bubble into MEM_WB.
- mem_req_o  out  1  memory request valid.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  ADDR_W  word-aligned address; bits [1:0] always 0.
- mem_wdata_o  out  DATA_W  write data.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  DATA_W  read data.
- sb_count_o  out  $clog2(SB_DEPTH)+1  occupied buffer entries.
- misaligned_o  out  1  access with addr_i[1:0] != 0.

Behaviour:
- Reset values: state IDLE; buffer emptied; rdata_o = 0; mem_req_o = 0; mem_we_o = 0; mem_addr_o = 0; mem_wdata_o = 0; sb_count_o = 0.
- Reset mid-operation:
  - Any in-flight transaction is abandoned and mem_req_o drops immediately.
  - A mem_rvalid_i arriving after reset is ignored.
  - In general, mem_rvalid_i is ignored in any state other than LD_WAIT.
- Store buffer is a circular FIFO with read/write pointers that wrap modulo SB_DEPTH.
  - Full: count == SB_DEPTH. Empty: count == 0.
  - Enqueue when req_write_i && !full: {addr_i[ADDR_W-1:2], 2'b00, wdata_i}.
  - Enqueue while full is never performed, even if a pop occurs in the same cycle.
  - Simultaneous enqueue and pop leaves the count unchanged.
- stall_o (combinational) = (req_read_i && state != LD_DONE) || (req_write_i && full).
- FSM states: IDLE, ST_REQ, LD_REQ, LD_WAIT, LD_DONE.
  - IDLE:
    - Buffer non-empty → ST_REQ (head entry).
    - Else req_read_i → LD_REQ.
    - Stores therefore drain before any load (program order preserved).
  - ST_REQ: mem_req_o = 1, mem_we_o = 1, address/data from head. On mem_gnt_i, pop head and go to IDLE. Stores expect no response.
  - LD_REQ: mem_req_o = 1, mem_we_o = 0, mem_addr_o = aligned addr_i. On mem_gnt_i, go to LD_WAIT.
  - LD_WAIT: mem_req_o = 0. On mem_rvalid_i, rdata_o <= mem_rdata_i and go to LD_DONE.
  - LD_DONE: stall_o = 0 for exactly one cycle; pipeline advances; next state IDLE.
- mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are registered. They are held stable while mem_req_o = 1 and mem_gnt_i = 0.
- Minimum load latency, empty buffer, gnt same cycle, rvalid next cycle: 3 stall cycles, with data on rdata_o in the 4th cycle.
- rdata_o holds its value until the next load completes.
- misaligned_o is combinational: (req_read_i | req_write_i) & |addr_i[1:0]. The access proceeds word-aligned.

Optional Feature:
- Macro: MEM_STAGE_STORE_FWD_EN.
- Defined:
  - In IDLE, a load whose word address matches any valid buffer entry takes the youngest matching data into rdata_o and goes directly to LD_DONE (1 stall cycle).
  - A load that misses goes to LD_REQ immediately, bypassing the buffered stores.
  - A buffer drain is started only when no load is pending.
- Undefined: the buffer always drains fully before any load is issued.

Test Plan:
- Reset check: assert rst_i = 0 mid-LD_WAIT, then release → mem_req_o = 0 and sb_count_o = 0 immediately; a stray mem_rvalid_i is ignored; the next load completes normally.
- Basic load: load 0x100 with empty buffer, gnt immediate, rvalid one cycle later with 0xDEADBEEF → stall_o high for exactly 3 cycles, then rdata_o = 0xDEADBEEF with stall_o = 0.
- Buffer fill: 5 back-to-back stores with SB_DEPTH = 4 and mem_gnt_i held 0 → sb_count_o reaches 4 and stall_o = 1 on the 5th store. Raise gnt → 5th enqueued after a pop; memory sees writes in program order.
- Store then load:
  - Store 0x200 ← 0x1234, then load 0x200, forwarding off → the write is granted before the read request; rdata_o = memory value.
  - Forwarding on → rdata_o = 0x1234 after 1 stall cycle and no read request is issued.
- Misaligned: load with addr_i = 0x103 → misaligned_o = 1 and mem_addr_o = 0x100.
- Gnt backpressure: mem_gnt_i low for 5 cycles during LD_REQ → mem_req_o, mem_addr_o and mem_we_o stay stable; stall_o remains 1 throughout.

Source files
------------

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM-stage controller and the external memory.
// Signal suffixes are relative to the controller: _o driven by it, _i driven by memory.
//   mem_req_o    request valid (held until granted)
//   mem_we_o     1 = write, 0 = read
//   mem_addr_o   word-aligned byte address
//   mem_wdata_o  write data
//   mem_gnt_i    request accepted this cycle
//   mem_rvalid_i read data valid
//   mem_rdata_i  read data
interface mem_stage_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory access controller for a 5-stage MIPS pipeline.
// Stores are posted into an in-order store buffer and drained to memory;
// loads stall the pipeline until their data returns.
// Optional feature macro: MEM_STAGE_STORE_FWD_EN (store-to-load forwarding
// from the buffer; missing loads bypass buffered stores).
// Ports:
//   clk_i, rst_i (async, active-low)
//   req_read_i, req_write_i, addr_i, wdata_i  from EX_MEM
//   rdata_o                                    load result to MEM_WB
//   stall_o (comb)                             pipeline freeze
//   sb_count_o                                 store buffer occupancy
//   misaligned_o (comb)                        addr_i[1:0] != 0 on an access
//   mem                                        memory bus (master side)
module mem_stage_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_read_i,
  input  logic                        req_write_i,
  input  logic [ADDR_W-1:0]           addr_i,
  input  logic [DATA_W-1:0]           wdata_i,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        stall_o,
  output logic [$clog2(SB_DEPTH):0]   sb_count_o,
  output logic                        misaligned_o,
  mem_stage_ctrl_if.master            mem
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    ST_REQ,
    LD_REQ,
    LD_WAIT,
    LD_DONE
  } state_t;

  state_t state, state_n;

  // Store buffer storage and pointers
  logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] sb_data [SB_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, empty, push, pop;

  // Registered memory-bus and result state with their next values
  logic              req_q, req_n;
  logic              we_q, we_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;

  logic [ADDR_W-1:0] aligned_addr;

  assign aligned_addr = {addr_i[ADDR_W-1:2], 2'b00};
  assign full         = (count == CNT_W'(SB_DEPTH));
  assign empty        = (count == '0);
  // A store stuck behind a full buffer is only taken once a later cycle sees space
  assign push         = req_write_i && !full;

  assign stall_o      = (req_read_i && (state != LD_DONE)) || (req_write_i && full);
  assign misaligned_o = (req_read_i | req_write_i) & (|addr_i[1:0]);

  assign rdata_o       = rdata_q;
  assign sb_count_o    = count;
  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;

`ifdef MEM_STAGE_STORE_FWD_EN
  // Youngest matching buffered store: scan oldest to newest, last hit wins
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  fwd_idx;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (sb_addr[fwd_idx] == aligned_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data[fwd_idx];
      end
    end
  end
`endif

  // Next-state and next registered outputs
  always_comb begin
    state_n = state;
    req_n   = 1'b0;
    we_n    = 1'b0;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = rdata_q;
    pop     = 1'b0;

    case (state)
      IDLE: begin
`ifdef MEM_STAGE_STORE_FWD_EN
        if (req_read_i) begin
          if (fwd_hit) begin
            rdata_n = fwd_data;
            state_n = LD_DONE;
          end else begin
            req_n   = 1'b1;
            addr_n  = aligned_addr;
            state_n = LD_REQ;
          end
        end else if (!empty) begin
          req_n   = 1'b1;
          we_n    = 1'b1;
          addr_n  = sb_addr[rd_ptr];
          wdata_n = sb_data[rd_ptr];
          state_n = ST_REQ;
        end
`else
        // Buffered stores always go first so loads observe program order
        if (!empty) begin
          req_n   = 1'b1;
          we_n    = 1'b1;
          addr_n  = sb_addr[rd_ptr];
          wdata_n = sb_data[rd_ptr];
          state_n = ST_REQ;
        end else if (req_read_i) begin
          req_n   = 1'b1;
          addr_n  = aligned_addr;
          state_n = LD_REQ;
        end
`endif
      end

      ST_REQ: begin
        if (mem.mem_gnt_i) begin
          pop     = 1'b1;
          state_n = IDLE;
        end else begin
          req_n = 1'b1;
          we_n  = 1'b1;
        end
      end

      LD_REQ: begin
        if (mem.mem_gnt_i) begin
          state_n = LD_WAIT;
        end else begin
          req_n = 1'b1;
        end
      end

      LD_WAIT: begin
        if (mem.mem_rvalid_i) begin
          rdata_n = mem.mem_rdata_i;
          state_n = LD_DONE;
        end
      end

      LD_DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_n;
      req_q   <= req_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      rdata_q <= rdata_n;
    end
  end

  // Store buffer FIFO; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr[i] <= '0;
        sb_data[i] <= '0;
      end
    end else begin
      if (push) begin
        sb_addr[wr_ptr] <= aligned_addr;
        sb_data[wr_ptr] <= wdata_i;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl with a behavioural data memory.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_read;
  logic        req_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic [2:0]  sb_count;
  logic        misaligned;

  mem_stage_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  mem_stage_ctrl #(.ADDR_W(32), .DATA_W(32), .SB_DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .req_read_i   (req_read),
    .req_write_i  (req_write),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rdata_o      (rdata),
    .stall_o      (stall),
    .sb_count_o   (sb_count),
    .misaligned_o (misaligned),
    .mem          (mif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Memory model knobs: gnt_mode 0 = never, 1 = always, 2 = random
  int          gnt_mode = 1;
  int          rv_delay = 0;
  bit          rv_rand  = 0;
  bit          rv_pend  = 0;
  int          rv_wait  = 0;
  logic [31:0] rv_data  = '0;

  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];
  logic [63:0] obs_wr [$];
  logic [63:0] exp_wr [$];
  logic [32:0] txn_log [$];
  logic [31:0] exp_rd [$];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Behavioural memory: grants, records accepted transactions, returns read data
  initial begin
    bit gnt_now;
    mif.mem_gnt_i    = 1'b0;
    mif.mem_rvalid_i = 1'b0;
    mif.mem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      mif.mem_rvalid_i = 1'b0;
      if (rv_pend) begin
        if (rv_wait == 0) begin
          mif.mem_rvalid_i = 1'b1;
          mif.mem_rdata_i  = rv_data;
          rv_pend          = 1'b0;
        end else begin
          rv_wait--;
        end
      end
      gnt_now = 1'b0;
      if (mif.mem_req_o && rst_n) begin
        if (gnt_mode == 1) gnt_now = 1'b1;
        else if (gnt_mode == 2) gnt_now = ($urandom_range(0, 2) != 0);
      end
      mif.mem_gnt_i = gnt_now;
      if (gnt_now) begin
        txn_log.push_back({mif.mem_we_o, mif.mem_addr_o});
        if (mif.mem_we_o) begin
          obs_wr.push_back({mif.mem_addr_o, mif.mem_wdata_o});
          mem_model[mif.mem_addr_o] = mif.mem_wdata_o;
        end else begin
          rv_pend = 1'b1;
          rv_wait = rv_rand ? int'($urandom_range(0, 3)) : rv_delay;
          rv_data = mem_model.exists(mif.mem_addr_o) ? mem_model[mif.mem_addr_o]
                                                     : dflt(mif.mem_addr_o);
        end
      end
    end
  end

  // Issue a load at the current negedge; returns at the negedge after completion
  task automatic do_load(input logic [31:0] a, input string nm, output int stalls);
    logic [31:0] e;
    logic [31:0] got_e;
    bit done;
    done      = 1'b0;
    req_read  = 1'b1;
    req_write = 1'b0;
    addr      = a;
    wdata     = '0;
    e = ref_mem.exists(word(a)) ? ref_mem[word(a)] : dflt(word(a));
    exp_rd.push_back(e);
    stalls = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (stall) begin
        stalls++;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      $display("FAIL %s: load never completed, stall_o still %b", nm, stall);
    end else begin
      got_e = exp_rd.pop_front();
      if (rdata !== got_e) $display("FAIL %s: rdata_o=%h expected %h", nm, rdata, got_e);
      else passed++;
    end
    @(negedge clk);
  endtask

  // Issue a store at the current negedge; returns at the negedge after it is enqueued
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input string nm);
    bit done;
    done      = 1'b0;
    req_write = 1'b1;
    req_read  = 1'b0;
    addr      = a;
    wdata     = d;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (stall) @(negedge clk);
      else done = 1'b1;
    end
    if (!done) begin
      checks++;
      $display("FAIL %s: store never accepted, stall_o=%b sb_count_o=%0d", nm, stall, sb_count);
    end else begin
      exp_wr.push_back({word(a), d});
      ref_mem[word(a)] = d;
    end
    @(negedge clk);
  endtask

  task automatic go_idle(input int n);
    req_read  = 1'b0;
    req_write = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for the buffer to empty and the bus to go quiet
  task automatic drain(input string nm);
    bit ok;
    ok        = 1'b0;
    req_read  = 1'b0;
    req_write = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (sb_count == 3'd0 && !mif.mem_req_o && !rv_pend) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      $display("FAIL %s: buffer did not drain, sb_count_o=%0d", nm, sb_count);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int s;
    req_read  = 1'b0;
    req_write = 1'b0;
    addr      = '0;
    wdata     = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({rdata, mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o, sb_count, stall} !== '0)
      $display("FAIL reset_values: rdata=%h req=%b we=%b addr=%h wdata=%h cnt=%0d stall=%b expected all 0",
               rdata, mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o, sb_count, stall);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while a store request is outstanding with buffered data
    gnt_mode = 0;
    do_store(32'h300, 32'h1111_2222, "reset_store");
    go_idle(1);
    #1;
    checks++;
    if (mif.mem_req_o !== 1'b1 || sb_count !== 3'd1)
      $display("FAIL reset_pre_store: req=%b cnt=%0d expected 1 and 1", mif.mem_req_o, sb_count);
    else passed++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (mif.mem_req_o !== 1'b0 || sb_count !== 3'd0)
      $display("FAIL reset_drop_store: req=%b cnt=%0d expected 0 and 0", mif.mem_req_o, sb_count);
    else passed++;
    exp_wr.delete();
    ref_mem.delete(32'h300);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while waiting for read data; its late rvalid must be ignored
    gnt_mode = 1;
    rv_delay = 5;
    req_read = 1'b1;
    addr     = 32'h40;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (mif.mem_req_o !== 1'b0 || stall !== 1'b1 || !rv_pend)
      $display("FAIL reset_pre_ldwait: req=%b stall=%b expected 0 and 1 with read outstanding",
               mif.mem_req_o, stall);
    else passed++;
    @(negedge clk);
    rst_n    = 1'b0;
    req_read = 1'b0;
    #1;
    checks++;
    if (mif.mem_req_o !== 1'b0 || sb_count !== 3'd0 || rdata !== 32'h0)
      $display("FAIL reset_ldwait: req=%b cnt=%0d rdata=%h expected 0,0,0", mif.mem_req_o, sb_count, rdata);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (rdata !== 32'h0 || stall !== 1'b0 || rv_pend)
      $display("FAIL reset_stray_rvalid: rdata=%h stall=%b expected 0 and 0", rdata, stall);
    else passed++;
    @(negedge clk);
    rv_delay = 0;
    do_load(32'h100, "reset_next_load", s);
    go_idle(1);
  endtask

  task automatic test_basic_load();
    int s;
    gnt_mode = 1;
    rv_delay = 0;
    do_load(32'h100, "basic_load", s);
    checks++;
    if (s !== 3) $display("FAIL basic_load_stalls: %0d stall cycles expected 3", s);
    else passed++;
    go_idle(1);
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    gnt_mode = 1;
    rv_delay = 0;
    do_load(32'h104, "b2b_load0", s1);
    do_load(32'h108, "b2b_load1", s2);
    checks++;
    if (s1 !== 3 || s2 !== 3) $display("FAIL b2b_stalls: %0d and %0d expected 3 and 3", s1, s2);
    else passed++;
    go_idle(1);
  endtask

  task automatic test_buffer_fill();
    logic [63:0] o, e;
    drain("fill_pre");
    obs_wr.delete();
    exp_wr.delete();
    gnt_mode = 0;
    for (int i = 0; i < 4; i++) do_store(32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), "fill_store");
    req_write = 1'b1;
    addr      = 32'h20;
    wdata     = 32'hA000_0004;
    #1;
    checks++;
    if (stall !== 1'b1 || sb_count !== 3'd4)
      $display("FAIL fill_full: stall=%b cnt=%0d expected 1 and 4", stall, sb_count);
    else passed++;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b1 || sb_count !== 3'd4 || obs_wr.size() != 0)
      $display("FAIL fill_hold: stall=%b cnt=%0d writes=%0d expected 1,4,0", stall, sb_count, obs_wr.size());
    else passed++;
    @(negedge clk);
    gnt_mode = 1;
    do_store(32'h20, 32'hA000_0004, "fill_store5");
    drain("fill_drain");
    checks++;
    if (obs_wr.size() != 5) $display("FAIL fill_wr_count: %0d writes expected 5", obs_wr.size());
    else passed++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front();
      o = obs_wr.pop_front();
      checks++;
      if (o !== e) $display("FAIL fill_wr_order: addr/data %h expected %h", o, e);
      else passed++;
    end
  endtask

  task automatic test_store_then_load();
    int s;
    int wi, ri;
    drain("stld_pre");
    txn_log.delete();
    gnt_mode = 1;
    rv_delay = 0;
    do_store(32'h200, 32'h1234, "stld_store");
    do_load(32'h200, "stld_load", s);
    wi = -1;
    ri = -1;
    foreach (txn_log[i]) begin
      if (txn_log[i] == {1'b1, 32'h200} && wi < 0) wi = i;
      if (txn_log[i] == {1'b0, 32'h200} && ri < 0) ri = i;
    end
`ifdef MEM_STAGE_STORE_FWD_EN
    checks++;
    if (s !== 1) $display("FAIL stld_fwd_stalls: %0d stall cycles expected 1", s);
    else passed++;
    checks++;
    if (ri >= 0) $display("FAIL stld_fwd_noread: read issued at log index %0d expected none", ri);
    else passed++;
`else
    checks++;
    if (s !== 5) $display("FAIL stld_stalls: %0d stall cycles expected 5", s);
    else passed++;
    checks++;
    if (wi < 0 || ri < 0 || wi > ri)
      $display("FAIL stld_order: write index %0d read index %0d expected write first", wi, ri);
    else passed++;
`endif
    drain("stld_drain");
    obs_wr.delete();
    exp_wr.delete();
  endtask

  task automatic test_misaligned_backpressure();
    int s;
    bit seen;
    logic [63:0] o;
    drain("mis_pre");
    obs_wr.delete();
    exp_wr.delete();
    gnt_mode  = 0;
    req_read  = 1'b1;
    req_write = 1'b0;
    addr      = 32'h103;
    #1;
    checks++;
    if (misaligned !== 1'b1) $display("FAIL mis_load_flag: misaligned_o=%b expected 1", misaligned);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (mif.mem_req_o) seen = 1'b1;
    end
    checks++;
    if (!seen || mif.mem_addr_o !== 32'h100 || mif.mem_we_o !== 1'b0)
      $display("FAIL mis_load_addr: req=%b addr=%h we=%b expected 1, 00000100, 0",
               mif.mem_req_o, mif.mem_addr_o, mif.mem_we_o);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (mif.mem_req_o !== 1'b1 || mif.mem_addr_o !== 32'h100 || mif.mem_we_o !== 1'b0 || stall !== 1'b1)
        $display("FAIL gnt_backpressure: cycle %0d req=%b addr=%h we=%b stall=%b expected 1,00000100,0,1",
                 i, mif.mem_req_o, mif.mem_addr_o, mif.mem_we_o, stall);
      else passed++;
    end
    @(negedge clk);
    gnt_mode = 1;
    do_load(32'h103, "mis_load_data", s);
    req_write = 1'b1;
    req_read  = 1'b0;
    addr      = 32'h207;
    wdata     = 32'hCAFE;
    #1;
    checks++;
    if (misaligned !== 1'b1) $display("FAIL mis_store_flag: misaligned_o=%b expected 1", misaligned);
    else passed++;
    do_store(32'h207, 32'hCAFE, "mis_store");
    req_write = 1'b0;
    addr      = 32'h3;
    #1;
    checks++;
    if (misaligned !== 1'b0) $display("FAIL mis_no_access: misaligned_o=%b expected 0", misaligned);
    else passed++;
    drain("mis_drain");
    checks++;
    if (obs_wr.size() != 1) begin
      $display("FAIL mis_store_wr: %0d writes expected 1", obs_wr.size());
    end else begin
      o = obs_wr.pop_front();
      if (o !== {32'h204, 32'hCAFE}) $display("FAIL mis_store_wr: %h expected %h", o, {32'h204, 32'hCAFE});
      else passed++;
    end
    exp_wr.delete();
  endtask

  task automatic test_random_traffic();
    int s;
    logic [31:0] a;
    logic [63:0] o, e;
    drain("rand_pre");
    obs_wr.delete();
    exp_wr.delete();
    gnt_mode = 2;
    rv_rand  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = 32'h400 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) do_store(a, $urandom, "rand_store");
      else do_load(a, "rand_load", s);
    end
    drain("rand_drain");
    checks++;
    if (obs_wr.size() != exp_wr.size())
      $display("FAIL rand_wr_count: %0d writes expected %0d", obs_wr.size(), exp_wr.size());
    else passed++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front();
      o = obs_wr.pop_front();
      checks++;
      if (o !== e) $display("FAIL rand_wr_order: addr/data %h expected %h", o, e);
      else passed++;
    end
    gnt_mode = 1;
    rv_rand  = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_read  = 1'b0;
    req_write = 1'b0;
    addr      = '0;
    wdata     = '0;
    mem_model[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100]   = 32'hDEADBEEF;
    test_reset();
    test_basic_load();
    test_back_to_back();
    test_buffer_fill();
    test_store_then_load();
    test_misaligned_backpressure();
    test_random_traffic();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Absolute watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1);
  end

endmodule
